// File: rtl/regfile_multiport_pkg.sv
// Shared types and constants for the multi-port register file and its clear sequencer.
package regfile_pkg;

    typedef enum logic {
        RF_IDLE  = 1'b0,
        RF_CLEAR = 1'b1
    } rf_state_t;

    localparam int RF_MIN_DEPTH = 4;

endpackage

// File: rtl/regfile_multiport_if.sv
// Register-file bus: read ports, write port and the clear handshake.
interface regfile_multiport_if #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 32,
    parameter int NREAD = 2
);
    localparam int AW = $clog2(DEPTH);

    logic [NREAD*AW-1:0]    ReadRegister;
    logic [NREAD*WIDTH-1:0] ReadData;
    logic [AW-1:0]          WriteRegister;
    logic [WIDTH-1:0]       WriteData;
    logic                   RegWrite;
    logic                   ClearReq;
    logic                   ClearBusy;
    logic                   ClearDone;
    logic                   WriteDropped;

    modport master (
        output ReadRegister, WriteRegister, WriteData, RegWrite, ClearReq,
        input  ReadData, ClearBusy, ClearDone, WriteDropped
    );

    modport slave (
        input  ReadRegister, WriteRegister, WriteData, RegWrite, ClearReq,
        output ReadData, ClearBusy, ClearDone, WriteDropped
    );

endinterface

// File: rtl/regfile_multiport_clear_fsm.sv
// Clear sequencer: walks idx from 1 to DEPTH-1 zeroing one register per cycle,
// and flags writes that arrive while the sweep owns the array.
module regfile_clear_fsm
    import regfile_pkg::*;
#(
    parameter int DEPTH = 32,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          Clk,
    input  logic          Reset_n,
    input  logic          ClearReq,
    input  logic          RegWrite,
    input  logic [AW-1:0] WriteRegister,
    output logic          ClearBusy,
    output logic          ClearDone,
    output logic          WriteDropped,
    output logic          writeAllowed,
    output logic          clearStrobe,
    output logic [AW-1:0] clearIdx
);
    localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

    rf_state_t     stateReg, stateNext;
    logic [AW-1:0] idxReg, idxNext;
    logic          doneReg, doneNext;
    logic          droppedReg, droppedNext;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            stateReg   <= RF_IDLE;
            idxReg     <= '0;
            doneReg    <= 1'b0;
            droppedReg <= 1'b0;
        end else begin
            stateReg   <= stateNext;
            idxReg     <= idxNext;
            doneReg    <= doneNext;
            droppedReg <= droppedNext;
        end
    end

    always_comb begin
        stateNext   = stateReg;
        idxNext     = idxReg;
        doneNext    = 1'b0;
        droppedNext = 1'b0;
        case (stateReg)
            RF_IDLE: begin
                if (ClearReq) begin
                    stateNext = RF_CLEAR;
                    idxNext   = AW'(1);
                end
            end
            RF_CLEAR: begin
                droppedNext = RegWrite && (WriteRegister != '0);
                // Terminate on an explicit compare so idx never needs to wrap.
                if (idxReg == LAST_IDX) begin
                    stateNext = RF_IDLE;
                    doneNext  = 1'b1;
                end else begin
                    idxNext = idxReg + AW'(1);
                end
            end
            default: stateNext = RF_IDLE;
        endcase
    end

    assign ClearBusy    = (stateReg == RF_CLEAR);
    assign ClearDone    = doneReg;
    assign WriteDropped = droppedReg;
    assign writeAllowed = (stateReg == RF_IDLE);
    assign clearStrobe  = (stateReg == RF_CLEAR);
    assign clearIdx     = idxReg;

endmodule

// File: rtl/regfile_multiport.sv
// Multi-read-port register file with r0 hardwired to zero and a run-time clear sweep.
// Optional same-cycle write-to-read forwarding is compiled in with REGFILE_BYPASS_EN.
module regfile_multiport
    import regfile_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 32,
    parameter int NREAD = 2
) (
    input logic                Clk,
    input logic                Reset_n,
    regfile_multiport_if.slave bus
);
    localparam int AW = $clog2(DEPTH);

    if (DEPTH < RF_MIN_DEPTH || DEPTH > 256 || (DEPTH & (DEPTH - 1)) != 0) begin : gBadDepth
        $error("regfile_multiport: DEPTH must be a power of two in 4..256");
    end
    if (NREAD < 1 || NREAD > 4) begin : gBadNread
        $error("regfile_multiport: NREAD must be in 1..4");
    end

    logic [WIDTH-1:0] regArray [DEPTH];
    logic             writeAllowed;
    logic             clearStrobe;
    logic [AW-1:0]    clearIdx;
    logic             writeEn;

    regfile_clear_fsm #(
        .DEPTH(DEPTH),
        .AW   (AW)
    ) clearFsm (
        .Clk          (Clk),
        .Reset_n      (Reset_n),
        .ClearReq     (bus.ClearReq),
        .RegWrite     (bus.RegWrite),
        .WriteRegister(bus.WriteRegister),
        .ClearBusy    (bus.ClearBusy),
        .ClearDone    (bus.ClearDone),
        .WriteDropped (bus.WriteDropped),
        .writeAllowed (writeAllowed),
        .clearStrobe  (clearStrobe),
        .clearIdx     (clearIdx)
    );

    assign writeEn = bus.RegWrite && writeAllowed && (bus.WriteRegister != '0);

    // Clear and write never coincide: writes are only accepted while idle.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                regArray[i] <= '0;
            end
        end else begin
            if (clearStrobe) begin
                regArray[clearIdx] <= '0;
            end
            if (writeEn) begin
                regArray[bus.WriteRegister] <= bus.WriteData;
            end
        end
    end

    genvar gi;
    for (gi = 0; gi < NREAD; gi++) begin : gRead
        logic [AW-1:0] rdAddr;
        assign rdAddr = bus.ReadRegister[gi*AW +: AW];
`ifdef REGFILE_BYPASS_EN
        logic bypassHit;
        assign bypassHit = writeEn && (rdAddr == bus.WriteRegister);
        assign bus.ReadData[gi*WIDTH +: WIDTH] = (rdAddr == '0) ? '0 :
                                                 bypassHit      ? bus.WriteData :
                                                                  regArray[rdAddr];
`else
        assign bus.ReadData[gi*WIDTH +: WIDTH] = (rdAddr == '0) ? '0 : regArray[rdAddr];
`endif
    end

endmodule

// File: tb/tb_regfile_multiport.sv
// Bench for regfile_multiport: directed and random cycles checked against an
// array-based model of the register file and its clear sweep.
module tb_regfile_multiport;
    localparam int WIDTH = 32;
    localparam int DEPTH = 32;
    localparam int NREAD = 2;
    localparam int AW    = 5;

    logic clk  = 1'b0;
    logic rstN = 1'b0;
    always #5 clk = ~clk;

    regfile_multiport_if #(.WIDTH(WIDTH), .DEPTH(DEPTH), .NREAD(NREAD)) bus ();

    regfile_multiport #(.WIDTH(WIDTH), .DEPTH(DEPTH), .NREAD(NREAD)) dut (
        .Clk    (clk),
        .Reset_n(rstN),
        .bus    (bus.slave)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: register contents plus clear progress.
    logic [31:0] mem [DEPTH];
    bit          busy;
    int          nextClr;
    bit          expDone;
    bit          expDrop;
    int          busyCycles, doneCount, dropCount, dropIssued;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] expRead(input int addr);
        if (addr == 0) return 32'h0;
`ifdef REGFILE_BYPASS_EN
        if (bus.RegWrite && !busy && bus.WriteRegister != '0 && int'(bus.WriteRegister) == addr)
            return bus.WriteData;
`endif
        return mem[addr];
    endfunction

    task automatic modelReset();
        for (int i = 0; i < DEPTH; i++) mem[i] = 32'h0;
        busy    = 1'b0;
        nextClr = 0;
        expDone = 1'b0;
        expDrop = 1'b0;
    endtask

    task automatic modelEdge();
        bit nd;
        bit np;
        int wa;
        nd = 1'b0;
        np = 1'b0;
        wa = int'(bus.WriteRegister);
        if (!busy) begin
            if (bus.RegWrite && wa != 0) mem[wa] = bus.WriteData;
            if (bus.ClearReq) begin
                busy    = 1'b1;
                nextClr = 1;
            end
        end else begin
            if (bus.RegWrite && wa != 0) np = 1'b1;
            mem[nextClr] = 32'h0;
            nextClr++;
            if (nextClr == DEPTH) begin
                busy = 1'b0;
                nd   = 1'b1;
            end
        end
        expDone = nd;
        expDrop = np;
    endtask

    task automatic checkAll(input string tag);
        chk({tag, "_busy"}, bus.ClearBusy, busy);
        chk({tag, "_done"}, bus.ClearDone, expDone);
        chk({tag, "_drop"}, bus.WriteDropped, expDrop);
        for (int p = 0; p < NREAD; p++) begin
            int a;
            a = int'(bus.ReadRegister[p*AW +: AW]);
            chk({tag, "_rd"}, bus.ReadData[p*WIDTH +: WIDTH], expRead(a));
        end
    endtask

    task automatic drive(input bit we, input int wa, input logic [31:0] wd,
                         input bit cr, input int ra0, input int ra1);
        bus.RegWrite      = we;
        bus.WriteRegister = AW'(wa);
        bus.WriteData     = wd;
        bus.ClearReq      = cr;
        bus.ReadRegister  = {AW'(ra1), AW'(ra0)};
    endtask

    // One clock transaction: check before the edge (same-cycle reads), then after it.
    task automatic cycle(input string tag);
        #1 checkAll({tag, "_pre"});
        @(posedge clk);
        modelEdge();
        #1 checkAll({tag, "_post"});
        if (bus.ClearBusy)    busyCycles++;
        if (bus.ClearDone)    doneCount++;
        if (bus.WriteDropped) dropCount++;
        $display("[%0t] %s we=%0b wa=%0d wd=%h cr=%0b busy=%0b done=%0b drop=%0b",
                 $time, tag, bus.RegWrite, bus.WriteRegister, bus.WriteData,
                 bus.ClearReq, bus.ClearBusy, bus.ClearDone, bus.WriteDropped);
    endtask

    task automatic sweepZero(input string tag);
        drive(0, 0, 32'h0, 0, 0, 0);
        for (int a = 0; a < DEPTH; a++) begin
            bus.ReadRegister = {AW'(0), AW'(a)};
            #1 chk(tag, bus.ReadData[WIDTH-1:0], 32'h0);
        end
        @(negedge clk);
        expDone = 1'b0;
        expDrop = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int wa;
        bit we;
        modelReset();
        drive(0, 0, 32'h0, 0, 5, 0);
        busyCycles = 0; doneCount = 0; dropCount = 0; dropIssued = 0;

        #12 checkAll("reset");
        @(negedge clk);
        rstN = 1'b1;

        // Write r5 then read r5 / r0
        drive(1, 5, 32'hDEADBEEF, 0, 5, 0);
        cycle("wr_r5");
        drive(0, 0, 32'h0, 0, 5, 0);
        #1;
        chk("r5_read", bus.ReadData[31:0], 32'hDEADBEEF);
        chk("r0_read", bus.ReadData[63:32], 32'h0);

        // Write to r0 is discarded silently
        drive(1, 0, 32'hFFFFFFFF, 0, 0, 0);
        cycle("wr_r0");
        chk("r0_after", bus.ReadData[31:0], 32'h0);
        chk("r0_nodrop", bus.WriteDropped, 1'b0);

        // Random reads/writes, some reading the address being written
        repeat (60) begin
            wa = int'($urandom_range(0, DEPTH - 1));
            drive($urandom_range(0, 1), wa, $urandom, 0,
                  ($urandom_range(0, 3) == 0) ? wa : int'($urandom_range(0, DEPTH - 1)),
                  int'($urandom_range(0, DEPTH - 1)));
            cycle("rand");
        end

        // Bypass: write r9 while reading it
        drive(1, 9, 32'h12345678, 0, 0, 0);
        cycle("pre_r9");
        drive(1, 9, 32'hA5A5A5A5, 0, 9, 9);
        #1;
`ifdef REGFILE_BYPASS_EN
        chk("bypass_r9", bus.ReadData[31:0], 32'hA5A5A5A5);
`else
        chk("nobypass_r9", bus.ReadData[31:0], 32'h12345678);
`endif
        cycle("wr_r9");
        chk("r9_after", bus.ReadData[63:32], 32'hA5A5A5A5);

        // Preload r1..r31 and run a full clear with writes attempted during it
        for (int r = 1; r < DEPTH; r++) begin
            drive(1, r, 32'h11111111, 0, r, 0);
            cycle("preload");
        end
        busyCycles = 0; doneCount = 0; dropCount = 0; dropIssued = 0;
        drive(0, 0, 32'h0, 1, 3, 20);
        cycle("clr_req");
        for (int k = 0; k < 40; k++) begin
            we = busy && (k % 5 == 2);
            if (we) dropIssued++;
            drive(we, 7, $urandom, busy ? 1'($urandom_range(0, 1)) : 1'b0, 3, 20);
            if (nextClr == 10 && busy) begin
                #1;
                chk("mid_r3", bus.ReadData[31:0], 32'h0);
                chk("mid_r20", bus.ReadData[63:32], 32'h11111111);
            end
            cycle("clr");
        end
        chk("clr_busy_cycles", 64'(busyCycles), 64'd31);
        chk("clr_done_count", 64'(doneCount), 64'd1);
        chk("clr_drop_count", 64'(dropCount), 64'(dropIssued));
        sweepZero("clr_zero");

        // ClearReq held high: back-to-back sequences
        busyCycles = 0; doneCount = 0;
        for (int k = 0; k < 70; k++) begin
            drive($urandom_range(0, 1), int'($urandom_range(0, DEPTH - 1)), $urandom, 1,
                  int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(0, DEPTH - 1)));
            cycle("held");
        end
        chk("held_done_count", 64'(doneCount), 64'd2);

        // Let the active sweep finish, then seed data and reset mid-clear at idx=10
        for (int k = 0; k < 40 && busy; k++) begin
            drive(0, 0, 32'h0, 0, 0, 0);
            cycle("drain");
        end
        chk("drain_idle", bus.ClearBusy, 1'b0);
        repeat (10) begin
            drive(1, int'($urandom_range(1, DEPTH - 1)), $urandom, 0, 0, 0);
            cycle("seed");
        end
        drive(0, 0, 32'h0, 1, 0, 0);
        cycle("rst_clr_req");
        for (int k = 0; k < 20 && nextClr < 10; k++) begin
            drive(0, 0, 32'h0, 0, 15, 25);
            cycle("rst_clr");
        end
        chk("rst_idx_reached", 64'(nextClr), 64'd10);
        #2 rstN = 1'b0;
        modelReset();
        #1;
        chk("rst_busy", bus.ClearBusy, 1'b0);
        checkAll("rst_async");
        doneCount = 0;
        repeat (2) begin
            @(posedge clk);
            #1 checkAll("rst_hold");
            if (bus.ClearDone) doneCount++;
        end
        @(negedge clk);
        rstN = 1'b1;
        sweepZero("rst_zero");
        repeat (5) begin
            drive(0, 0, 32'h0, 0, 0, 0);
            cycle("post_rst");
        end
        chk("rst_no_done", 64'(doneCount), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
